// File: rtl/imm_encoder_if.sv
// Request/beat handshake bundle for the immediate encoder.
// The master side issues requests and consumes beats; the slave side is the encoder.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  CEU;
  logic [31:0] Imm;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] Dout;
  logic [2:0]  out_ceu;
  logic        out_last;
  logic        out_err;

  modport master (
    output in_valid, CEU, Imm, out_ready,
    input  in_ready, out_valid, Dout, out_ceu, out_last, out_err
  );

  modport slave (
    input  in_valid, CEU, Imm, out_ready,
    output in_ready, out_valid, Dout, out_ceu, out_last, out_err
  );
endinterface

// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into instruction[31:7] for a given format code,
// with per-beat range/alignment checks and a two-beat LUI+ADDI expansion for LI.
//
// state   | meaning
// S_EMPTY | no beat held, output idle
// S_FULL  | final beat of a request held on the output
// S_HI    | LI upper beat held, lower beat waiting in lo_r
module imm_encoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  imm_encoder_if.slave     bus,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_HI} state_t;

  state_t      state, state_nxt;
  logic [31:0] imm;
  logic [24:0] pk_d, dout_r, lo_r;
  logic [19:0] li_hi;
  logic [2:0]  pk_ceu, ceu_r;
  logic        pk_err, li_two, last_r, err_r;
  logic        fits_i, fits_b, fits_j;
  logic        out_valid_c, in_ready_c, accept, consume;

  assign imm    = bus.Imm;
  assign fits_i = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits_b = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits_j = (&imm[31:20]) | ~(|imm[31:20]);
  // Rounded upper part so that hi<<12 plus the sign-extended low 12 bits restores Imm.
  assign li_hi  = imm[31:12] + {19'b0, imm[11]};
  assign li_two = (bus.CEU == 3'b110) && !fits_i;

  always_comb begin
    pk_d   = '0;
    pk_err = 1'b0;
    pk_ceu = bus.CEU;
    case (bus.CEU)
      3'b000: begin
        pk_d[24:13] = imm[11:0];
        pk_err      = !fits_i;
      end
      3'b001: begin
        pk_d[17:13] = imm[4:0];
        pk_err      = |imm[31:5];
      end
      3'b010: begin
        pk_d[24:18] = imm[11:5];
        pk_d[4:0]   = imm[4:0];
        pk_err      = !fits_i;
      end
      3'b011: begin
        pk_d[24:5] = imm[31:12];
        pk_err     = |imm[11:0];
      end
      3'b100: begin
        pk_d[24]    = imm[12];
        pk_d[23:18] = imm[10:5];
        pk_d[4:1]   = imm[4:1];
        pk_d[0]     = imm[11];
        pk_err      = !fits_b || imm[0];
      end
      3'b101: begin
        pk_d[24]    = imm[20];
        pk_d[23:14] = imm[10:1];
        pk_d[13]    = imm[11];
        pk_d[12:5]  = imm[19:12];
        pk_err      = !fits_j || imm[0];
      end
      3'b110: begin
        if (fits_i) begin
          pk_d[24:13] = imm[11:0];
          pk_ceu      = 3'b000;
        end else begin
          pk_d[24:5] = li_hi;
          pk_ceu     = 3'b011;
        end
      end
      default: pk_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY, S_FULL: begin
        if (accept)                             state_nxt = li_two ? S_HI : S_FULL;
        else if (state == S_FULL && bus.out_ready) state_nxt = S_EMPTY;
      end
      S_HI:    if (bus.out_ready) state_nxt = S_FULL;
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_comb begin
    out_valid_c = (state != S_EMPTY);
    in_ready_c  = (state != S_HI) && (!out_valid_c || bus.out_ready);
    accept      = bus.in_valid && in_ready_c;
    consume     = out_valid_c && bus.out_ready;
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.Dout      = dout_r;
  assign bus.out_ceu   = ceu_r;
  assign bus.out_last  = last_r;
  assign bus.out_err   = err_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r    <= '0;
      lo_r      <= '0;
      ceu_r     <= '0;
      last_r    <= 1'b0;
      err_r     <= 1'b0;
      err_count <= '0;
    end else begin
      if (accept) begin
        dout_r <= pk_d;
        ceu_r  <= pk_ceu;
        last_r <= !li_two;
        err_r  <= pk_err;
        lo_r   <= {imm[11:0], 13'b0};
      end else if (state == S_HI && bus.out_ready) begin
        dout_r <= lo_r;
        ceu_r  <= 3'b000;
        last_r <= 1'b1;
        err_r  <= 1'b0;
      end
      if (consume && err_r && (err_count != {CNT_W{1'b1}}))
        err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: a queue-based beat model built from the
// instruction-word layout of each format, directed scenarios, then random traffic.
module tb_imm_encoder;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [CNT_W-1:0] err_count;

  imm_encoder_if bus ();

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [24:0] d;
    logic [2:0]  ceu;
    logic        last;
    logic        err;
  } beat_t;

  beat_t       q[$];
  int          exp_cnt = 0;
  int          tests   = 0;
  int          fails   = 0;
  bit          armed   = 0;
  beat_t       mb0, mb1, pb0, pb1;
  int          mn, pn;
  bit          mrdy;
  logic [31:0] edges[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_range(input logic [31:0] v, input int bits);
    longint s;
    s = longint'($signed(v));
    return (s >= -(longint'(1) << (bits - 1))) && (s < (longint'(1) << (bits - 1)));
  endfunction

  // Model beats are built as full instruction words; the field is bits [31:7].
  function automatic beat_t mk(input logic [31:0] instr, input logic [2:0] c,
                               input bit last, input bit err);
    beat_t b;
    b.d    = instr[31:7];
    b.ceu  = c;
    b.last = last;
    b.err  = err;
    return b;
  endfunction

  function automatic void expand(input logic [2:0] c, input logic [31:0] imm,
                                 output beat_t b0, output beat_t b1, output int n);
    logic [31:0] hi;
    n  = 1;
    b1 = '0;
    case (c)
      3'd0: b0 = mk({imm[11:0], 20'b0}, c, 1, !in_range(imm, 12));
      3'd1: b0 = mk({7'b0, imm[4:0], 20'b0}, c, 1, imm > 32'd31);
      3'd2: b0 = mk({imm[11:5], 13'b0, imm[4:0], 7'b0}, c, 1, !in_range(imm, 12));
      3'd3: b0 = mk({imm[31:12], 12'b0}, c, 1, (imm % 32'd4096) != 0);
      3'd4: b0 = mk({imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0}, c, 1,
                    !in_range(imm, 13) || imm[0]);
      3'd5: b0 = mk({imm[20], imm[10:1], imm[11], imm[19:12], 12'b0}, c, 1,
                    !in_range(imm, 21) || imm[0]);
      3'd6: begin
        if (in_range(imm, 12)) b0 = mk({imm[11:0], 20'b0}, 3'd0, 1, 0);
        else begin
          hi = imm + 32'h800;
          b0 = mk({hi[31:12], 12'b0}, 3'd3, 0, 0);
          b1 = mk({imm[11:0], 20'b0}, 3'd0, 1, 0);
          n  = 2;
        end
      end
      default: b0 = mk(32'b0, c, 1, 1);
    endcase
  endfunction

  function automatic bit model_ready();
    return !(q.size() > 0 && !q[0].last) && (q.size() == 0 || bus.out_ready);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      exp_cnt = 0;
      armed   = 1;
    end else if (armed) begin
      mrdy = model_ready();
      if (q.size() > 0 && bus.out_ready) begin
        if (q[0].err && exp_cnt < CNT_MAX) exp_cnt++;
        void'(q.pop_front());
      end
      if (bus.in_valid && mrdy) begin
        expand(bus.CEU, bus.Imm, mb0, mb1, mn);
        q.push_back(mb0);
        if (mn == 2) q.push_back(mb1);
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
      chk("in_ready", 32'(bus.in_ready), 32'(model_ready()));
      chk("err_count", 32'(err_count), 32'(exp_cnt));
      if (q.size() > 0) begin
        chk("Dout", 32'(bus.Dout), 32'(q[0].d));
        chk("out_ceu", 32'(bus.out_ceu), 32'(q[0].ceu));
        chk("out_last", 32'(bus.out_last), 32'(q[0].last));
        chk("out_err", 32'(bus.out_err), 32'(q[0].err));
      end
    end
  end

  task automatic set_in(input bit v, input logic [2:0] c, input logic [31:0] imm, input bit r);
    bus.in_valid  = v;
    bus.CEU       = c;
    bus.Imm       = imm;
    bus.out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_imm();
    case ($urandom_range(0, 4))
      0:       return 32'($signed($urandom_range(0, 4095)) - 2048);
      1:       return $urandom();
      2:       return edges[$urandom_range(0, 13)] + 32'($urandom_range(0, 2)) - 32'd1;
      3:       return $urandom() & 32'hFFFFF000;
      default: return 32'($urandom_range(0, 40)) & ~32'd1;
    endcase
  endfunction

  initial begin
    edges = '{32'h0, 32'h7FF, 32'h800, 32'hFFFFF800, 32'hFFFFF7FF, 32'hFFF, 32'h1000,
              32'hFFFFF000, 32'h7FFFF800, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF,
              32'h100000, 32'hFFF00000};
    rst = 1'b1;
    set_in(0, 3'd0, 32'h0, 0);

    // Pin the model against hand-derived encodings.
    expand(3'd6, 32'h12345FFF, pb0, pb1, pn);
    chk("model_li_n", 32'(pn), 32'd2);
    chk("model_li_hi", 32'(pb0.d), 32'h02468C0);
    chk("model_li_lo", 32'(pb1.d), 32'h1FFE000);
    expand(3'd0, 32'hFFFFF800, pb0, pb1, pn);
    chk("model_i", 32'({pb0.d, pb0.err}), {7'b0, 25'h1000000} << 1);
    expand(3'd5, 32'h000FFFFE, pb0, pb1, pn);
    chk("model_j", 32'(pb0.d), 32'hFFFFE0);
    expand(3'd4, 32'h00000801, pb0, pb1, pn);
    chk("model_b", 32'({pb0.d, pb0.err}), 32'h3);
    expand(3'd6, 32'h000007FF, pb0, pb1, pn);
    chk("model_li_short", 32'(pn), 32'd1);

    tick(); tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_Dout", 32'(bus.Dout), 32'd0);
    chk("rst_flags", 32'({bus.out_ceu, bus.out_last, bus.out_err}), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;

    set_in(1, 3'd4, 32'h00000801, 1); tick();
    chk("b_Dout", 32'(bus.Dout), 32'h0000001);
    chk("b_err", 32'(bus.out_err), 32'd1);
    set_in(1, 3'd0, 32'hFFFFF800, 1); tick();
    chk("b_err_count", 32'(err_count), 32'd1);
    chk("i_Dout", 32'(bus.Dout), 32'h1000000);
    chk("i_flags", 32'({bus.out_valid, bus.out_last, bus.out_err}), 32'b110);
    set_in(1, 3'd0, 32'h00000800, 1); tick();
    chk("i_range_err", 32'(bus.out_err), 32'd1);
    set_in(1, 3'd5, 32'h000FFFFE, 1); tick();
    chk("j_Dout", 32'(bus.Dout), 32'hFFFFE0);
    chk("j_err", 32'(bus.out_err), 32'd0);
    set_in(1, 3'd6, 32'h12345FFF, 1); tick();
    chk("li1_ceu", 32'(bus.out_ceu), 32'd3);
    chk("li1_Dout", 32'(bus.Dout), 32'h02468C0);
    chk("li1_last", 32'(bus.out_last), 32'd0);
    chk("li1_in_ready", 32'(bus.in_ready), 32'd0);
    set_in(1, 3'd6, 32'h000007FF, 1); tick();
    chk("li2_ceu", 32'(bus.out_ceu), 32'd0);
    chk("li2_Dout", 32'(bus.Dout), 32'h1FFE000);
    chk("li2_last", 32'(bus.out_last), 32'd1);
    tick();
    chk("li_short_Dout", 32'(bus.Dout), 32'hFFE000);
    chk("li_short_ceu", 32'({bus.out_ceu, bus.out_last}), 32'd1);

    set_in(1, 3'd2, 32'h00000ABC, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_Dout", 32'(bus.Dout), 32'hFFE000);
    end
    for (int i = 0; i < 5; i++) begin
      set_in(1, 3'd1, 32'(i), 1); tick();
      chk("stream_valid", 32'(bus.out_valid), 32'd1);
      chk("stream_Dout", 32'(bus.Dout), 32'(i) << 13);
    end
    set_in(0, 3'd0, 32'h0, 1); tick(); tick();

    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in(1, 3'd7, $urandom(), 1); tick();
    end
    set_in(0, 3'd0, 32'h0, 1); tick(); tick();
    chk("sat_err_count", 32'(err_count), 32'(CNT_MAX));

    set_in(1, 3'd6, 32'h12345FFF, 0); tick();
    chk("mid_li_ceu", 32'(bus.out_ceu), 32'd3);
    set_in(0, 3'd0, 32'h0, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_li_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    tick(); tick();
    chk("mid_li_no_low", 32'(bus.out_valid), 32'd0);
    chk("mid_li_err_count", 32'(err_count), 32'd0);

    for (int i = 0; i < 4000; i++) begin
      set_in($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), rand_imm(),
             $urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0;
    set_in(0, 3'd0, 32'h0, 1);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the immediate extender. Takes a 32-bit immediate value plus a format code (same CEU encoding as the extender) and produces the 25-bit instruction field, instruction[31:7]. The immediate bits sit in their format positions; all other bits are zero.
- Sits in the instruction-builder / self-test path that assembles instruction words for the core.
- Range and alignment are checked per beat.
- CEU=110 is a load-immediate expansion: it emits a LUI beat plus an ADDI-immediate beat when the value does not fit in 12 bits.
- Valid/ready on both sides; output is registered.

Parameters:
CNT_W, 8, width of saturating error counter err_count.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&in_ready
CEU  in  3  format: 000 I, 001 shamt, 010 S, 011 U, 100 B, 101 J, 110 LI expansion, 111 reserved
Imm  in  32  immediate value, two's complement
out_valid  out  1  output beat valid
out_ready  in  1  beat consumed when out_valid&out_ready
Dout  out  25  packed field for instruction[31:7]
out_ceu  out  3  format of current beat (000 or 011 for LI beats; else copy of CEU)
out_last  out  1  last beat of request
out_err  out  1  current beat out of range / misaligned / reserved
err_count  out  CNT_W  beats with out_err=1, saturating

Behaviour:

Reset (synchronous):
- out_valid=0, Dout=0, out_ceu=0, out_last=0, out_err=0, err_count=0, state=S_EMPTY.
- Any pending LI low beat is discarded.

Packing (Dint index = instruction bit - 7); unlisted Dout bits are 0:
- 000 I: Dout[24:13]=Imm[11:0]. err if Imm[31:11] not all equal.
- 001 shamt: Dout[17:13]=Imm[4:0]. err if Imm[31:5]!=0.
- 010 S: Dout[24:18]=Imm[11:5], Dout[4:0]=Imm[4:0]. err as I.
- 011 U: Dout[24:5]=Imm[31:12]. err if Imm[11:0]!=0.
- 100 B: Dout[24]=Imm[12], Dout[23:18]=Imm[10:5], Dout[4:1]=Imm[4:1], Dout[0]=Imm[11]. err if Imm[31:12] not all equal or Imm[0]=1.
- 101 J: Dout[24]=Imm[20], Dout[23:14]=Imm[10:1], Dout[13]=Imm[11], Dout[12:5]=Imm[19:12]. err if Imm[31:20] not all equal or Imm[0]=1.
- 111: Dout=0, out_err=1, single beat.
- On error, Dout still carries the truncated packing.

LI (110):
- If Imm fits the I range: single I beat, out_ceu=000.
- Otherwise two beats:
  - hi=(Imm+32'h800)[31:12], 32-bit wrap.
  - Beat 1: U packing of hi, out_ceu=011, out_last=0.
  - Beat 2: I packing of Imm[11:0], out_ceu=000, out_last=1.
  - Neither beat errors.

FSM:
- States: S_EMPTY (no beat held), S_FULL (last beat held), S_HI (LI high beat held, low beat pending).
- in_ready = (state!=S_HI) && (!out_valid || out_ready). It is combinational from state and out_ready.
- Accept: beat registered, out_valid=1 on next cycle (latency 1). Next state is S_HI for a two-beat LI, else S_FULL.
- S_FULL, out_ready=1 with no accept: go to S_EMPTY, out_valid=0.
- S_FULL, simultaneous consume+accept: new beat loaded, no bubble (1 request/cycle).
- S_HI, out_ready=1: load low beat, go to S_FULL. in_ready stays 0 during that cycle.
- While out_valid && !out_ready: Dout, out_ceu, out_last, out_err held stable.

err_count:
- Increments on each consumed beat with out_err=1.
- Saturates at 2^CNT_W-1.

rst has priority over all handshakes in the same cycle.

Test Plan:
- I: CEU=000, Imm=32'hFFFFF800 -> one cycle later out_valid=1, Dout=25'h1000000, out_err=0, out_last=1. Imm=32'h00000800 -> out_err=1.
- B misaligned: CEU=100, Imm=32'h00000801 -> Dout=25'h0000001, out_err=1; after consume, err_count=1.
- J: CEU=101, Imm=32'h000FFFFE -> Dout=25'hFFFFE0, out_err=0.
- LI: CEU=110, Imm=32'h12345FFF, out_ready=1:
  - Beat 1: out_ceu=011, Dout=25'h02468C0, out_last=0.
  - Beat 2 (next cycle): out_ceu=000, Dout=25'h1FFE000, out_last=1.
  - in_ready=0 during beat 1.
  - Imm=32'h000007FF -> single I beat.
- Backpressure/throughput: out_ready=0 for 3 cycles -> outputs stable, in_ready=0. Then out_ready=1 with continuous in_valid -> one beat per cycle, no bubble. With CNT_W=2, five CEU=111 beats -> err_count=3.
- Reset mid-LI: rst asserted while beat 1 is held -> next cycle out_valid=0, state empty, low beat never emitted, err_count=0.
